// File: rtl/datapath_pkg.sv
// Shared types for the scratchpad request path: opcode encoding, packet layout
// and the GEMM select field width.
package datapath_pkg;

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'b00,
        OP_LOAD    = 2'b01,
        OP_STORE   = 2'b10,
        OP_GEMM    = 2'b11
    } spad_op_t;

    localparam int SPAD_ADDR_W = 32;
    localparam int GEMM_SEL_W  = 16;

    typedef struct packed {
        spad_op_t               op;
        logic [3:0]             mrd;
        logic [SPAD_ADDR_W-1:0] addr;
    } spad_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer, which
// moves one past the granted channel whenever the grant is taken.
module rr_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic             found;
    int               idx;

    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = (int'(ptr) + off) % NUM_CH;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                ptr_next   = PTR_W'((idx + 1) % NUM_CH);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/spad_req_queue.sv
// Multi-channel scratchpad request queue: round-robin admission into a FIFO
// feeding the scratchpad. Optional same-cycle bypass under SPAD_REQ_BYPASS_EN.
module spad_req_queue
    import datapath_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    localparam int PKT_W = 6 + ADDR_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_CH-1:0]             req_valid,
    output logic [NUM_CH-1:0]             req_ready,
    input  logic [NUM_CH-1:0][1:0]        req_op,
    input  logic [NUM_CH-1:0][3:0]        req_mrd,
    input  logic [NUM_CH-1:0][ADDR_W-1:0] req_addr,
    input  logic                          flush,
    output logic                          spad_valid,
    output logic [PKT_W-1:0]              spad_pkt,
    input  logic                          spad_ready,
    output logic [CNT_W-1:0]              count,
    output logic                          err_illegal
);

    function automatic logic [ADDR_W-1:0] gemm_mask(input logic [1:0] op,
                                                     input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = a;
        if (spad_op_t'(op) == OP_GEMM) begin
            for (int b = GEMM_SEL_W; b < ADDR_W; b++) r[b] = 1'b0;
        end
        return r;
    endfunction

    logic [NUM_CH-1:0] grant;
    logic [1:0]        g_op;
    logic [3:0]        g_mrd;
    logic [ADDR_W-1:0] g_addr;
    logic [PKT_W-1:0]  g_pkt;
    logic              can_accept;
    logic              accept;
    logic              legal;
    logic              byp;
    logic              push;
    logic              pop;
    logic              q_valid;
    logic [PKT_W-1:0]  q_pkt;
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [PKT_W-1:0]  mem [DEPTH];

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    always_comb begin
        g_op   = '0;
        g_mrd  = '0;
        g_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                g_op   = req_op[i];
                g_mrd  = req_mrd[i];
                g_addr = req_addr[i];
            end
        end
    end

    // Admission: ready is gated by reset directly so it drops the moment RST rises.
    assign g_pkt      = {g_op, g_mrd, gemm_mask(g_op, g_addr)};
    assign legal      = (spad_op_t'(g_op) != OP_ILLEGAL);
    assign can_accept = !RST && !flush && (count < CNT_W'(DEPTH));
    assign req_ready  = grant & {NUM_CH{can_accept}};
    assign accept     = |req_ready;

    assign q_valid = (count != '0);
    assign q_pkt   = q_valid ? mem[head] : '0;
    assign pop     = q_valid && spad_ready;

`ifdef SPAD_REQ_BYPASS_EN
    assign byp        = accept && legal && !q_valid && spad_ready;
    assign spad_valid = q_valid || byp;
    assign spad_pkt   = byp ? g_pkt : q_pkt;
`else
    assign byp        = 1'b0;
    assign spad_valid = q_valid;
    assign spad_pkt   = q_pkt;
`endif

    assign push = accept && legal && !byp;

    // Storage stage: payload only, no reset needed since count qualifies reads.
    always_ff @(posedge CLK) begin
        if (push) mem[tail] <= g_pkt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_illegal <= 1'b0;
        end else if (accept && !legal) begin
            err_illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spad_req_queue.sv
// Directed self-checking bench for spad_req_queue with hand-computed expectations.
module tb_spad_req_queue;
    import datapath_pkg::*;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int PKT_W  = 38;
    localparam int CNT_W  = 4;

    logic                          CLK = 1'b0;
    logic                          RST;
    logic [NUM_CH-1:0]             req_valid;
    logic [NUM_CH-1:0]             req_ready;
    logic [NUM_CH-1:0][1:0]        req_op;
    logic [NUM_CH-1:0][3:0]        req_mrd;
    logic [NUM_CH-1:0][ADDR_W-1:0] req_addr;
    logic                          flush;
    logic                          spad_valid;
    logic [PKT_W-1:0]              spad_pkt;
    logic                          spad_ready;
    logic [CNT_W-1:0]              count;
    logic                          err_illegal;

    int errors = 0;
    int checks = 0;
    logic [PKT_W-1:0] exp_prev;

    always #5 CLK = ~CLK;

    spad_req_queue #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_mrd     (req_mrd),
        .req_addr    (req_addr),
        .flush       (flush),
        .spad_valid  (spad_valid),
        .spad_pkt    (spad_pkt),
        .spad_ready  (spad_ready),
        .count       (count),
        .err_illegal (err_illegal)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk(input logic [1:0] op, input logic [3:0] mrd,
                                            input logic [31:0] a);
        return {op, mrd, a};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int ch, input logic v, input logic [1:0] op,
                         input logic [3:0] mrd, input logic [31:0] a);
        req_valid[ch] = v;
        req_op[ch]    = op;
        req_mrd[ch]   = mrd;
        req_addr[ch]  = a;
    endtask

    task automatic idle();
        req_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; req_valid = '0; req_op = '0; req_mrd = '0; req_addr = '0;
        flush = 1'b0; spad_ready = 1'b0;
        drive(0, 1'b1, 2'b01, 4'h0, 32'h1);
        #3;
        check("rst_count", count, 0);
        check("rst_valid", spad_valid, 0);
        check("rst_pkt", spad_pkt, 0);
        check("rst_ready", req_ready, 0);
        check("rst_err", err_illegal, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        idle();
        step();

`ifndef SPAD_REQ_BYPASS_EN
        // Fairness: both channels every cycle, queue drains as it fills.
        spad_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 2'b01, 4'h1, 32'h10 + k);
            drive(1, 1'b1, 2'b10, 4'h2, 32'h20 + k);
            #1;
            check("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_latency", spad_valid, (k > 0) ? 1'b1 : 1'b0);
            if (k > 0) begin
                check("rr_order", spad_pkt, exp_prev);
                check("rr_count_pushpop", count, 1);
            end
            exp_prev = (k % 2 == 0) ? mk(2'b01, 4'h1, 32'h10 + k) : mk(2'b10, 4'h2, 32'h20 + k);
            step();
        end
        idle();
        check("rr_last_pkt", spad_pkt, exp_prev);
        check("rr_last_count", count, 1);
        step();
        check("rr_drain_count", count, 0);
        check("rr_drain_valid", spad_valid, 0);

        // Fill to full with wrap, refuse push at full even with pop, then push+pop at DEPTH-1.
        spad_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 2'b01, 4'h0, 32'h100 + i);
            #1;
            check("fill_ready", req_ready, 2'b01);
            step();
        end
        check("full_count", count, 8);
        check("full_head", spad_pkt, mk(2'b01, 4'h0, 32'h100));
        drive(0, 1'b1, 2'b01, 4'h0, 32'h108);
        spad_ready = 1'b1;
        #1;
        check("full_ready_with_pop", req_ready, 2'b00);
        step();
        check("after_full_pop_count", count, 7);
        #1;
        check("at7_ready", req_ready, 2'b01);
        check("at7_head", spad_pkt, mk(2'b01, 4'h0, 32'h101));
        step();
        check("at7_pushpop_count", count, 7);
        idle();
        for (int i = 2; i < 9; i++) begin
            check("drain_order", spad_pkt, mk(2'b01, 4'h0, 32'h100 + i));
            step();
        end
        check("drain_count", count, 0);
        check("drain_valid", spad_valid, 0);

        // GEMM select masking, and no same-cycle visibility without bypass.
        spad_ready = 1'b0;
        drive(1, 1'b1, 2'b11, 4'b1000, 32'hDEADBEEF);
        #1;
        check("gemm_ready", req_ready, 2'b10);
        check("gemm_no_bypass", spad_valid, 0);
        step();
        idle();
        check("gemm_pkt", spad_pkt, mk(2'b11, 4'b1000, 32'h0000BEEF));
        check("gemm_count", count, 1);
        spad_ready = 1'b1;
        step();
        check("gemm_pop_count", count, 0);

        // Illegal op: accepted, discarded, sticky flag.
        spad_ready = 1'b0;
        drive(0, 1'b1, 2'b00, 4'h3, 32'h55);
        #1;
        check("illegal_ready", req_ready, 2'b01);
        check("illegal_err_before", err_illegal, 0);
        step();
        idle();
        check("illegal_count", count, 0);
        check("illegal_valid", spad_valid, 0);
        check("illegal_err", err_illegal, 1);

        // Flush at count 3 with a simultaneous push; pointer and error flag survive.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 2'b01, 4'h0, 32'h300 + i);
            step();
        end
        check("preflush_count", count, 3);
        drive(0, 1'b1, 2'b01, 4'h0, 32'h333);
        flush = 1'b1;
        #1;
        check("flush_ready", req_ready, 2'b00);
        step();
        flush = 1'b0;
        idle();
        check("flush_count", count, 0);
        check("flush_valid", spad_valid, 0);
        check("flush_err_kept", err_illegal, 1);
        drive(0, 1'b1, 2'b01, 4'h0, 32'h444);
        drive(1, 1'b1, 2'b10, 4'h5, 32'h555);
        #1;
        check("flush_rr_kept", req_ready, 2'b10);
        step();
        idle();
        check("postflush_pkt", spad_pkt, mk(2'b10, 4'h5, 32'h555));
        check("postflush_count", count, 1);
        spad_ready = 1'b1;
        step();
        check("postflush_drain", count, 0);
`else
        // Bypass: empty queue with ready scratchpad passes the request straight through.
        spad_ready = 1'b1;
        drive(0, 1'b1, 2'b01, 4'h0, 32'h200);
        #1;
        check("byp_valid", spad_valid, 1);
        check("byp_pkt", spad_pkt, mk(2'b01, 4'h0, 32'h200));
        check("byp_ready", req_ready, 2'b01);
        step();
        idle();
        check("byp_count", count, 0);
        check("byp_valid_after", spad_valid, 0);
        spad_ready = 1'b0;
        drive(0, 1'b1, 2'b01, 4'h0, 32'h201);
        #1;
        check("nobyp_valid", spad_valid, 0);
        step();
        idle();
        check("nobyp_count", count, 1);
        check("nobyp_pkt", spad_pkt, mk(2'b01, 4'h0, 32'h201));
        spad_ready = 1'b1;
        step();
        check("nobyp_drain", count, 0);
`endif

        // Asynchronous reset mid-stream with a request held valid.
        spad_ready = 1'b0;
        drive(0, 1'b1, 2'b01, 4'h0, 32'h600);
        step();
        drive(0, 1'b1, 2'b01, 4'h0, 32'h601);
        step();
        check("prereset_count", count, 2);
        drive(0, 1'b1, 2'b01, 4'h0, 32'h602);
        #2;
        RST = 1'b1;
        #1;
        check("midrst_count", count, 0);
        check("midrst_valid", spad_valid, 0);
        check("midrst_pkt", spad_pkt, 0);
        check("midrst_ready", req_ready, 0);
        check("midrst_err", err_illegal, 0);
        @(negedge CLK);
        RST = 1'b0;
        drive(0, 1'b1, 2'b01, 4'h0, 32'h777);
        drive(1, 1'b1, 2'b10, 4'h0, 32'h778);
        #1;
        check("postrst_rr", req_ready, 2'b01);
        step();
        idle();
        check("postrst_pkt", spad_pkt, mk(2'b01, 4'h0, 32'h777));
        check("postrst_count", count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spad_req_queue.md
SPAD_REQ_QUEUE -- requirements
Module: spad_req_queue

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requesting channels (ch0 = matrix load/store FU, ch1 = GEMM FU).
REQ-002 SHALL have parameter DEPTH, default 8, queue entries, power of two, >= 2.
REQ-003 SHALL have parameter ADDR_W, default 32, address field width; PKT_W = 6 + ADDR_W.
REQ-004 SHALL have ports, in this order:
- CLK  in  1  the single clock.
- RST  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel accept; handshake when valid && ready.
- req_op  in  NUM_CH x 2  01 load, 10 store, 11 gemm, 00 illegal.
- req_mrd  in  NUM_CH x 4  matrix register / new-weight select.
- req_addr  in  NUM_CH x ADDR_W  matrix address or gemm select.
- flush  in  1  discard all queued and in-flight requests.
- spad_valid  out  1  head packet valid.
- spad_pkt  out  PKT_W  head packet, {op, mrd, addr}.
- spad_ready  in  1  scratchpad accepts head.
- count  out  clog2(DEPTH)+1  occupancy.
- err_illegal  out  1  sticky illegal-op flag.

Function
REQ-005 SHALL accept at most one request per cycle, granting a single channel by round-robin among asserted req_valid.
REQ-006 SHALL make the round-robin pointer one past the last granted channel, and leave it unchanged when there is no grant.
REQ-007 SHALL drive req_ready[i] high only for the granted channel, and only when count < DEPTH and flush is low.
REQ-008 SHALL, for an accepted request, write {op, mrd, addr} at the tail.
- For op 11, addr[ADDR_W-1:16] SHALL be forced to zero.
REQ-009 SHALL accept and discard an accepted request with op 00, setting err_illegal; err_illegal stays set until reset.
REQ-010 SHALL pop the head when spad_valid && spad_ready.
REQ-011 SHALL, on push and pop in the same cycle, leave count unchanged, including at count = DEPTH-1 and count = 1.
REQ-012 SHALL never accept a push when count = DEPTH, even if a pop occurs that cycle.
REQ-013 SHALL let pointers wrap modulo DEPTH; count SHALL distinguish full from empty.
REQ-014 SHALL drive spad_valid = (count != 0) without bypass, and hold spad_pkt stable while spad_valid && !spad_ready.
REQ-015 SHALL make a pushed packet visible at spad_pkt one cycle after acceptance (latency 1) when bypass is disabled.
REQ-016 SHALL, on flush, zero pointers and count next cycle and deassert all req_ready that cycle.
- Flush SHALL take priority over simultaneous push and pop.
- The round-robin pointer and err_illegal SHALL be kept.
REQ-017 SHALL preserve per-channel and global order: packets leave in acceptance order.

Reset
REQ-018 SHALL, while RST is high, immediately force:
- head, tail and count to 0;
- spad_valid to 0, spad_pkt to 0, req_ready to 0;
- round-robin pointer to 0, err_illegal to 0.
REQ-019 SHALL drop any partially handshaken request when RST is asserted mid-operation; the first legal push after release goes to entry 0.

Configuration
REQ-020 SHALL provide macro SPAD_REQ_BYPASS_EN.
REQ-021 SHALL, when SPAD_REQ_BYPASS_EN is defined and count = 0 and spad_ready = 1, pass a granted legal request combinationally to spad_pkt with spad_valid = 1 in the same cycle, without writing it to the queue.
REQ-022 SHALL, without SPAD_REQ_BYPASS_EN, have no combinational path from req_* to spad_*.

Structure
REQ-023 SHALL place in datapath_pkg:
- spad_op_t (2-bit enum: ILLEGAL, LOAD, STORE, GEMM);
- spad_pkt_t packed struct {op, mrd, addr};
- constant GEMM_SEL_W = 16.
REQ-024 SHALL instantiate one sub-module, rr_arbiter, parameterised by NUM_CH, providing the one-hot grant and pointer update.

Verification
REQ-025 SHALL cover round-robin fairness: ch0 and ch1 both valid every cycle, spad_ready = 1 -> grants alternate 0,1,0,1; spad_pkt order matches.
REQ-026 SHALL cover fill/full: spad_ready = 0, 8 pushes from ch0 (addr 0x100..0x107) -> count = 8, req_ready = 0; then spad_ready = 1 -> pops 0x100..0x107 in order, with wrap.
REQ-027 SHALL cover gemm masking: ch1 op 11, addr 0xDEADBEEF, mrd 4'b1000 -> spad_pkt = {2'b11, 4'b1000, 32'h0000BEEF}.
REQ-028 SHALL cover illegal op: op 00 request -> req_ready high, count unchanged, err_illegal = 1 persisting until RST.
REQ-029 SHALL cover flush with a simultaneous push at count = 3 -> count = 0 next cycle, spad_valid = 0, and the push is lost.
REQ-030 SHALL cover async reset mid-stream, plus bypass: RST pulsed between edges -> outputs zero immediately; with SPAD_REQ_BYPASS_EN, empty queue and push of 0x200 -> spad_pkt addr 0x200 in the same cycle, count stays 0.
